// File: rtl/vga_screen_arbiter.sv
// ---------------------------------------------------------------------------
// vga_screen_arbiter
//
// Chooses which of three screen renderers (START, GAME, OVER) drives the VGA
// DAC, and sequences the screens START -> GAME -> OVER -> START. Screen
// changes are requested at any time, but they only take effect on a frame
// boundary (the falling edge of vsync), so a frame is never split between
// two screens.
//
// Optional build feature:
//   VGA_BLANK_FRAME_EN  - when defined, the first frame after every screen
//                         change is forced black (vga_rgb = 0) until the
//                         next frame_tick. The renderer enables already
//                         point at the new screen during that frame.
//
// Parameters:
//   OVER_FRAMES  - frames the game-over screen is held before returning
//                  to START (8-bit counter, saturating)
//   SYNC_STAGES  - depth of the key input synchronizers (>= 1)
//
// Ports:
//   clk            in   pixel clock, the only clock
//   rst_n          in   synchronous active-low reset
//   sync_vsync     in   vsync, low during the frame's sync pulse
//   sync_out_sig   in   active-video flag
//   start_key      in   raw start button (async, active-high)
//   restart_key    in   raw restart button (async, active-high)
//   game_over      in   level, high while the game is lost
//   start_rgb      in   RGB332 pixel from the start renderer
//   game_rgb       in   RGB332 pixel from the game renderer
//   over_rgb       in   RGB332 pixel from the game-over renderer
//   vga_rgb        out  registered, arbitrated pixel (1 cycle latency)
//   screen_sel     out  current screen / FSM state: 0 START, 1 GAME, 2 OVER
//   start_en       out  one-hot renderer enables, from the registered state
//   game_en        out
//   over_en        out
//   game_init      out  one-cycle pulse on the first cycle in GAME
//
// Handshake: there is no valid/ready handshake here. Requests are latched
// into a single pending flag; the flag is consumed (and cleared) by the
// transition it causes on a later frame_tick.
// ---------------------------------------------------------------------------
module vga_screen_arbiter #(
   parameter int unsigned OVER_FRAMES = 180,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sync_vsync,
   input  logic       sync_out_sig,
   input  logic       start_key,
   input  logic       restart_key,
   input  logic       game_over,
   input  logic [7:0] start_rgb,
   input  logic [7:0] game_rgb,
   input  logic [7:0] over_rgb,
   output logic [7:0] vga_rgb,
   output logic [1:0] screen_sel,
   output logic       start_en,
   output logic       game_en,
   output logic       over_en,
   output logic       game_init
);

   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_GAME  = 2'd1,
      S_OVER  = 2'd2
   } state_e;

   localparam logic [7:0] OVER_MAX = 8'(OVER_FRAMES);

   // ------------------------------------------------------------------
   // Key synchronizers and rising-edge detectors
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] start_sync_q;
   logic [SYNC_STAGES-1:0] restart_sync_q;
   logic [SYNC_STAGES:0]   start_shift;
   logic [SYNC_STAGES:0]   restart_shift;
   logic                   start_prev_q;
   logic                   restart_prev_q;
   logic                   start_pulse;
   logic                   restart_pulse;

   assign start_shift   = {start_sync_q, start_key};
   assign restart_shift = {restart_sync_q, restart_key};

   assign start_pulse   = start_sync_q[SYNC_STAGES-1]   & ~start_prev_q;
   assign restart_pulse = restart_sync_q[SYNC_STAGES-1] & ~restart_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_sync_q   <= '0;
         restart_sync_q <= '0;
         start_prev_q   <= 1'b0;
         restart_prev_q <= 1'b0;
      end else begin
         start_sync_q   <= start_shift[SYNC_STAGES-1:0];
         restart_sync_q <= restart_shift[SYNC_STAGES-1:0];
         start_prev_q   <= start_sync_q[SYNC_STAGES-1];
         restart_prev_q <= restart_sync_q[SYNC_STAGES-1];
      end
   end

   // ------------------------------------------------------------------
   // Frame tick: falling edge of vsync
   // ------------------------------------------------------------------
   logic vsync_prev_q;
   logic frame_tick;

   assign frame_tick = vsync_prev_q & ~sync_vsync;

   always_ff @(posedge clk) begin
      if (!rst_n) vsync_prev_q <= 1'b0;
      else        vsync_prev_q <= sync_vsync;
   end

   // ------------------------------------------------------------------
   // Screen FSM
   // ------------------------------------------------------------------
   state_e     state_q, state_d;
   logic       pending_q, pending_d;
   logic [7:0] cnt_q, cnt_d;
   logic       game_init_q, game_init_d;
   logic       req;
   logic       transition;

   // The pending flag must already be set before the tick that consumes
   // it, so a request landing on the tick itself waits one more frame.
   assign transition = frame_tick & pending_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_START;
         pending_q   <= 1'b0;
         cnt_q       <= 8'd0;
         game_init_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         game_init_q <= game_init_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      cnt_d       = cnt_q;
      game_init_d = 1'b0;
      req         = 1'b0;

      // Each state listens only to its own request source.
      case (state_q)
         S_START: req = start_pulse;
         S_GAME:  req = game_over;
         S_OVER:  req = restart_pulse | (cnt_q == OVER_MAX);
         default: req = 1'b0;
      endcase

      if (transition) begin
         pending_d = 1'b0;
         case (state_q)
            S_START: begin
               state_d     = S_GAME;
               game_init_d = 1'b1;
            end
            S_GAME: begin
               state_d = S_OVER;
               cnt_d   = 8'd0;
            end
            default: state_d = S_START;
         endcase
      end else begin
         if (!pending_q && req) pending_d = 1'b1;
         if (frame_tick && state_q == S_OVER && cnt_q < OVER_MAX)
            cnt_d = cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Optional blank first frame after a screen change
   // ------------------------------------------------------------------
   logic rgb_mask;

`ifdef VGA_BLANK_FRAME_EN
   logic blank_q;

   always_ff @(posedge clk) begin
      if (!rst_n)          blank_q <= 1'b0;
      else if (transition) blank_q <= 1'b1;
      else if (frame_tick) blank_q <= 1'b0;
   end

   assign rgb_mask = ~blank_q;
`else
   assign rgb_mask = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Pixel mux, registered
   // ------------------------------------------------------------------
   logic [7:0] sel_rgb;
   logic [7:0] vga_rgb_q, vga_rgb_d;

   always_comb begin
      sel_rgb = 8'h00;
      case (state_q)
         S_START: sel_rgb = start_rgb;
         S_GAME:  sel_rgb = game_rgb;
         S_OVER:  sel_rgb = over_rgb;
         default: sel_rgb = 8'h00;
      endcase
      vga_rgb_d = (sync_out_sig && rgb_mask) ? sel_rgb : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vga_rgb_q <= 8'h00;
      else        vga_rgb_q <= vga_rgb_d;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign vga_rgb    = vga_rgb_q;
   assign screen_sel = state_q;
   assign start_en   = (state_q == S_START);
   assign game_en    = (state_q == S_GAME);
   assign over_en    = (state_q == S_OVER);
   assign game_init  = game_init_q;

endmodule

// File: tb/tb_vga_screen_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_screen_arbiter
//
// Directed scenarios followed by a randomized run. A reference model kept in
// the bench predicts the screen, enables, game_init and pixel for every
// cycle; the DUT is compared against it at each negedge, with extra
// constant checks at the scenario milestones.
// ---------------------------------------------------------------------------
module tb_vga_screen_arbiter;

   localparam int OF = 4;    // game-over hold frames
   localparam int SS = 2;    // synchronizer depth
   localparam int FL = 20;   // cycles per frame

`ifdef VGA_BLANK_FRAME_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sync_vsync = 1'b1;
   logic       sync_out_sig = 1'b0;
   logic       start_key = 1'b0;
   logic       restart_key = 1'b0;
   logic       game_over = 1'b0;
   logic [7:0] start_rgb = 8'h00;
   logic [7:0] game_rgb = 8'h00;
   logic [7:0] over_rgb = 8'h00;
   logic [7:0] vga_rgb;
   logic [1:0] screen_sel;
   logic       start_en, game_en, over_en, game_init;

   always #5 clk = ~clk;

   vga_screen_arbiter #(.OVER_FRAMES(OF), .SYNC_STAGES(SS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sync_vsync   (sync_vsync),
      .sync_out_sig (sync_out_sig),
      .start_key    (start_key),
      .restart_key  (restart_key),
      .game_over    (game_over),
      .start_rgb    (start_rgb),
      .game_rgb     (game_rgb),
      .over_rgb     (over_rgb),
      .vga_rgb      (vga_rgb),
      .screen_sel   (screen_sel),
      .start_en     (start_en),
      .game_en      (game_en),
      .over_en      (over_en),
      .game_init    (game_init)
   );

   // ---------------- counters ----------------
   int vectors = 0;
   int miscompares = 0;
   int fpos = 0;           // frame position of the next clock edge
   bit rand_video = 1'b0;

   // ---------------- reference model ----------------
   // Screen: 0 START, 1 GAME, 2 OVER.
   int       m_screen = 0;
   bit       m_pending = 1'b0;
   int       m_frames = 0;     // frames counted in OVER
   bit       m_blank = 1'b0;
   bit       m_init = 1'b0;
   bit       m_tick = 1'b0;    // last edge was a frame tick
   bit       m_vs_prev = 1'b0;
   logic [7:0] m_vga = 8'h00;
   // Raw key samples, oldest first; SS+1 entries are enough to see an
   // edge that has crossed the synchronizer.
   bit start_hist[$];
   bit restart_hist[$];

   function automatic bit rose(input bit q[$]);
      return q[1] && !q[0];
   endfunction

   task automatic clear_hist();
      start_hist.delete();
      restart_hist.delete();
      for (int i = 0; i < SS + 1; i++) begin
         start_hist.push_back(1'b0);
         restart_hist.push_back(1'b0);
      end
   endtask

   task automatic model_edge();
      bit sp, rp, req, tick;
      logic [7:0] pix;
      if (!rst_n) begin
         m_screen = 0; m_pending = 0; m_frames = 0; m_blank = 0;
         m_init = 0; m_vga = 8'h00; m_vs_prev = 0; m_tick = 0;
         clear_hist();
         return;
      end
      sp   = rose(start_hist);
      rp   = rose(restart_hist);
      tick = m_vs_prev && !sync_vsync;
      pix  = (m_screen == 0) ? start_rgb : (m_screen == 1) ? game_rgb : over_rgb;
      m_vga = (sync_out_sig && !(BLANK && m_blank)) ? pix : 8'h00;
      req = (m_screen == 0) ? sp : (m_screen == 1) ? game_over : (rp || m_frames == OF);
      m_init = 1'b0;
      if (tick && m_pending) begin
         m_screen  = (m_screen + 1) % 3;
         m_pending = 1'b0;
         m_blank   = 1'b1;
         m_frames  = 0;
         m_init    = (m_screen == 1);
      end else begin
         if (req) m_pending = 1'b1;
         if (tick) begin
            m_blank = 1'b0;
            if (m_screen == 2 && m_frames < OF) m_frames++;
         end
      end
      m_tick = tick;
      m_vs_prev = sync_vsync;
      start_hist.push_back(start_key);     void'(start_hist.pop_front());
      restart_hist.push_back(restart_key); void'(restart_hist.pop_front());
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("screen_sel", {6'b0, screen_sel}, 8'(m_screen));
      check("start_en",   {7'b0, start_en},   {7'b0, m_screen == 0});
      check("game_en",    {7'b0, game_en},    {7'b0, m_screen == 1});
      check("over_en",    {7'b0, over_en},    {7'b0, m_screen == 2});
      check("game_init",  {7'b0, game_init},  {7'b0, m_init});
      check("vga_rgb",    vga_rgb,            m_vga);
   endtask

   // ---------------- driver ----------------
   task automatic step();
      sync_vsync = (fpos >= 2);
      if (rand_video) begin
         sync_out_sig = 1'($urandom_range(0, 1));
         start_rgb    = 8'($urandom);
         game_rgb     = 8'($urandom);
         over_rgb     = 8'($urandom);
      end else begin
         sync_out_sig = (fpos >= 4 && fpos < 18);
      end
      @(posedge clk);
      model_edge();
      fpos = (fpos + 1) % FL;
      @(negedge clk);
      compare_all();
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic step_to_pos(input int p);
      for (int i = 0; i < FL && fpos != p; i++) step();
   endtask

   task automatic wait_screen(input string tag, input int s, input int budget);
      int n;
      n = 0;
      while (screen_sel !== 2'(s) && n < budget) begin
         step();
         n++;
      end
      check(tag, {6'b0, screen_sel}, 8'(s));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ticks;
      clear_hist();

      // Reset
      rst_n = 1'b0;
      step_n(3);
      check("rst_sel", {6'b0, screen_sel}, 8'd0);
      check("rst_start_en", {7'b0, start_en}, 8'd1);
      check("rst_vga", vga_rgb, 8'h00);
      rst_n = 1'b1;
      step_n(FL);

      // Start key held 10 cycles mid-frame -> GAME on next tick
      step_to_pos(8);
      start_key = 1'b1;
      step_n(10);
      start_key = 1'b0;
      ticks = 0;
      while (game_init !== 1'b1 && ticks < 3 * FL) begin
         step();
         ticks++;
      end
      check("init_seen", {7'b0, game_init}, 8'd1);
      check("init_sel", {6'b0, screen_sel}, 8'd1);
      check("init_game_en", {7'b0, game_en}, 8'd1);
      step();
      check("init_one_cycle", {7'b0, game_init}, 8'd0);

      // game_over -> OVER, then OF counted ticks plus one -> START
      game_over = 1'b1;
      wait_screen("to_over", 2, 3 * FL);
      game_over = 1'b0;
      ticks = 0;
      for (int i = 0; i < 8 * FL && screen_sel !== 2'd0; i++) begin
         step();
         if (m_tick) ticks++;
      end
      check("over_ticks", 8'(ticks), 8'(OF + 1));
      check("over_back_start", {6'b0, screen_sel}, 8'd0);

      // Start pulse coinciding with frame_tick -> switch one frame later
      step_to_pos(FL - 2);
      start_key = 1'b1;
      step_n(3);
      check("coincide_tick", {7'b0, m_tick}, 8'd1);
      check("coincide_hold", {6'b0, screen_sel}, 8'd0);
      start_key = 1'b0;
      step_n(FL - 1);
      check("coincide_wait", {6'b0, screen_sel}, 8'd0);
      step();
      check("coincide_switch", {6'b0, screen_sel}, 8'd1);

      // Reset while GAME->OVER is pending: no transition afterwards
      step_to_pos(6);
      game_over = 1'b1;
      step_n(3);
      game_over = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_pending_sel", {6'b0, screen_sel}, 8'd0);
      step_n(2 * FL);
      check("rst_no_trans", {6'b0, screen_sel}, 8'd0);

      // Pixel latency on the START screen
      start_rgb = 8'hE0;
      step_to_pos(4);
      step();
      check("rgb_on", vga_rgb, 8'hE0);
      step_to_pos(18);
      check("rgb_last_active", vga_rgb, 8'hE0);
      step();
      check("rgb_off", vga_rgb, 8'h00);

      // First GAME frame (blank when the feature is built in)
      game_rgb = 8'h1C;
      step_to_pos(8);
      start_key = 1'b1;
      step_n(4);
      start_key = 1'b0;
      wait_screen("blank_to_game", 1, 3 * FL);
      step_to_pos(10);
      check("first_frame", vga_rgb, BLANK ? 8'h00 : 8'h1C);
      step_n(FL);
      check("second_frame", vga_rgb, 8'h1C);

      // Randomized traffic
      rand_video = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) start_key = ~start_key;
         if ($urandom_range(0, 11) == 0) restart_key = ~restart_key;
         if ($urandom_range(0, 29) == 0) game_over = ~game_over;
         rst_n = ($urandom_range(0, 399) != 0);
         step();
      end
      rst_n = 1'b1;
      step_n(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "time limit");
   end

endmodule
